// File: rtl/store_narrow_unit_if.sv
// -----------------------------------------------------------------------------
// store_narrow_unit_if
//   Bundles the store request handshake and the word-only data memory bus used
//   by store_narrow_unit.
//
//   Request side (from EX/MEM stage):
//     req_valid_i   store request valid
//     req_ready_o   unit idle, request accepted on valid && ready at clk edge
//     addr_i        byte address of the store
//     wdata_i       register data (low bits used for byte/half stores)
//     size_i        00 byte, 01 half, 10 word, 11 illegal
//   Memory side (to Data_Memory):
//     mem_addr_o    word-aligned address
//     mem_rd_o      read request, level, held until mem_rvalid_i
//     mem_rdata_i   read data, valid with mem_rvalid_i
//     mem_rvalid_i  read data valid
//     mem_wr_o      write request, level, held until mem_wack_i
//     mem_wdata_o   merged write word
//     mem_wack_i    write accepted
//   Status:
//     done_o        one-cycle pulse, store committed
//     err_o         one-cycle pulse, misaligned/illegal store
//
//   Modports:
//     slave   the store unit itself
//     master  the surrounding pipeline/memory (or a testbench)
// -----------------------------------------------------------------------------
interface store_narrow_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [1:0]        size_i;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_rvalid_i;
    logic              mem_wr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_wack_i;

    logic              done_o;
    logic              err_o;

    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  addr_i,
        input  wdata_i,
        input  size_i,
        output mem_addr_o,
        output mem_rd_o,
        input  mem_rdata_i,
        input  mem_rvalid_i,
        output mem_wr_o,
        output mem_wdata_o,
        input  mem_wack_i,
        output done_o,
        output err_o
    );

    modport master (
        output req_valid_i,
        input  req_ready_o,
        output addr_i,
        output wdata_i,
        output size_i,
        input  mem_addr_o,
        input  mem_rd_o,
        output mem_rdata_i,
        output mem_rvalid_i,
        input  mem_wr_o,
        input  mem_wdata_o,
        output mem_wack_i,
        input  done_o,
        input  err_o
    );
endinterface

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
//   Store-path narrowing unit. Takes a 32-bit register value plus a byte
//   address and access size, and writes it into a word-only data memory.
//   Byte and half stores are done as read-modify-write (read the word, merge
//   the new lane(s), write the word back); word stores are written directly.
//   The pipe is stalled through req_ready_o while a store is in flight.
//
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   asynchronous reset, active low
//     bus     store_narrow_unit_if.slave (request handshake, memory bus,
//             done/err status pulses)
//
//   Parameter:
//     ADDR_W  byte-address width; data width is fixed at 32 bits
//
//   Sequencing: IDLE -> (RD ->) WR -> DONE -> IDLE, or IDLE -> ERR -> IDLE for
//   misaligned/illegal requests. Every output is registered except
//   req_ready_o, which is simply "state is IDLE".
// -----------------------------------------------------------------------------
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    store_narrow_unit_if.slave  bus
);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state_q, state_n;

    // Latched request; the request inputs are free to change once accepted.
    logic [ADDR_W-1:0] addr_q,  addr_n;
    logic [31:0]       data_q,  data_n;
    logic [1:0]        size_q,  size_n;

    // Registered memory-side and status outputs.
    logic [31:0]       wdata_q, wdata_n;
    logic              rd_q,    rd_n;
    logic              wr_q,    wr_n;
    logic              done_q,  done_n;
    logic              err_q,   err_n;

    // Illegal size code, or a half/word access that is not naturally aligned.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lo[0];
            SIZE_W:  bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane merge: lane n occupies bits 8n+7:8n. Only the lanes
    // targeted by the store are replaced; all others keep the memory word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] reg_data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            SIZE_B: begin
                case (lane)
                    2'd0:    w[7:0]   = reg_data[7:0];
                    2'd1:    w[15:8]  = reg_data[7:0];
                    2'd2:    w[23:16] = reg_data[7:0];
                    default: w[31:24] = reg_data[7:0];
                endcase
            end
            SIZE_H: begin
                if (lane[1]) begin
                    w[31:16] = reg_data[15:0];
                end else begin
                    w[15:0]  = reg_data[15:0];
                end
            end
            default: w = reg_data;
        endcase
        return w;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        data_n  = data_q;
        size_n  = size_q;
        wdata_n = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_n = bus.addr_i;
                    data_n = bus.wdata_i;
                    size_n = bus.size_i;
                    if (is_illegal(bus.size_i, bus.addr_i[1:0])) begin
                        state_n = ERR;
                    end else if (bus.size_i == SIZE_W) begin
                        state_n = WR;
                        wdata_n = bus.wdata_i;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (bus.mem_rvalid_i) begin
                    wdata_n = merge_word(bus.mem_rdata_i, data_q, size_q, addr_q[1:0]);
                    state_n = WR;
                end
            end
            WR: begin
                if (bus.mem_wack_i) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Request/status levels follow the state being entered, so they are
        // registered together with it and line up cycle for cycle.
        rd_n   = (state_n == RD);
        wr_n   = (state_n == WR);
        done_n = (state_n == DONE);
        err_n  = (state_n == ERR);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            size_q  <= size_n;
            wdata_q <= wdata_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_rd_o    = rd_q;
    assign bus.mem_wr_o    = wr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// -----------------------------------------------------------------------------
// tb_store_narrow_unit
//   Directed bench for store_narrow_unit. A small word memory model answers
//   read/write requests with programmable wait states and can inject stray
//   rvalid/wack pulses. Each store pushes its expected outcome onto a
//   scoreboard queue; the entry is popped and compared once the store retires.
// -----------------------------------------------------------------------------
module tb_store_narrow_unit;

    localparam int ADDR_W = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    store_narrow_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:1023];
    int rd_delay = 0;
    int wr_delay = 0;
    bit stray_rv = 1'b0;
    bit stray_wk = 1'b0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    always @(negedge clk_i) begin
        bus.mem_rvalid_i <= 1'b0;
        bus.mem_wack_i   <= 1'b0;
        bus.mem_rdata_i  <= 32'hFFFF_FFFF;
        if (bus.mem_rd_o) begin
            if (rd_cnt >= rd_delay) begin
                bus.mem_rvalid_i <= 1'b1;
                bus.mem_rdata_i  <= mem[bus.mem_addr_o[11:2]];
            end
            rd_cnt <= rd_cnt + 1;
        end else begin
            rd_cnt <= 0;
        end
        if (bus.mem_wr_o) begin
            if (wr_cnt >= wr_delay) begin
                bus.mem_wack_i <= 1'b1;
                mem[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
                wr_log.push_back({bus.mem_addr_o, bus.mem_wdata_o});
            end
            wr_cnt <= wr_cnt + 1;
        end else begin
            wr_cnt <= 0;
        end
        if (stray_rv && bus.mem_wr_o) bus.mem_rvalid_i <= 1'b1;
        if (stray_wk && bus.mem_rd_o) bus.mem_wack_i   <= 1'b1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd_cyc;
        int          wr_cyc;
        int          end_idx;
    } exp_t;
    exp_t exp_q[$];

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one store in the current (ready) cycle and follow it until the
    // unit is ready again, then compare against the scoreboard entry.
    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input bit exp_err, input logic [31:0] exp_wd);
        exp_t e;
        exp_t got;
        wr_t  w;
        int   rdc, wrc, donec, errc, done_idx, err_idx, idx;
        bit   fin;
        e.err     = exp_err;
        e.addr    = {a[31:2], 2'b00};
        e.wdata   = exp_wd;
        e.rd_cyc  = (exp_err || sz == 2'b10) ? 0 : rd_delay + 1;
        e.wr_cyc  = exp_err ? 0 : wr_delay + 1;
        e.end_idx = exp_err ? 2 : e.rd_cyc + e.wr_cyc + 2;
        exp_q.push_back(e);

        chk({tag, "/ready_before"}, {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i = 1'b1;
        bus.addr_i      = a;
        bus.wdata_i     = d;
        bus.size_i      = sz;
        tick();
        // Scramble the request inputs: the unit must work from its own copies.
        bus.req_valid_i = 1'b0;
        bus.addr_i      = ~a;
        bus.wdata_i     = ~d;
        bus.size_i      = sz ^ 2'b01;

        rdc = 0; wrc = 0; donec = 0; errc = 0; done_idx = 0; err_idx = 0;
        idx = 1; fin = 1'b0;
        while (!fin) begin
            if (bus.mem_rd_o) begin
                rdc++;
                chk({tag, "/rd_addr"}, bus.mem_addr_o, e.addr);
            end
            if (bus.mem_wr_o) begin
                wrc++;
                chk({tag, "/wr_addr"}, bus.mem_addr_o, e.addr);
                chk({tag, "/wr_data"}, bus.mem_wdata_o, e.wdata);
            end
            if (bus.done_o) begin donec++; done_idx = idx; end
            if (bus.err_o)  begin errc++;  err_idx  = idx; end
            if (bus.req_ready_o || idx >= 60) begin
                fin = 1'b1;
            end else begin
                tick();
                idx++;
            end
        end

        got = exp_q.pop_front();
        chk({tag, "/ready_cycle"}, idx, got.end_idx);
        chk({tag, "/rd_cycles"}, rdc, got.rd_cyc);
        chk({tag, "/wr_cycles"}, wrc, got.wr_cyc);
        chk({tag, "/done_pulses"}, donec, got.err ? 0 : 1);
        chk({tag, "/err_pulses"}, errc, got.err ? 1 : 0);
        if (got.err) begin
            chk({tag, "/err_cycle"}, err_idx, 1);
        end else begin
            chk({tag, "/done_cycle"}, done_idx, got.end_idx - 1);
        end
        chk({tag, "/mem_writes"}, wr_log.size(), got.err ? 0 : 1);
        if (wr_log.size() > 0) begin
            w = wr_log.pop_front();
            chk({tag, "/logged_addr"}, w.addr, got.addr);
            chk({tag, "/logged_data"}, w.data, got.wdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid_i = 1'b0;
        bus.addr_i      = '0;
        bus.wdata_i     = '0;
        bus.size_i      = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst/ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst/mem_rd", {31'd0, bus.mem_rd_o}, 32'd0);
        chk("rst/mem_wr", {31'd0, bus.mem_wr_o}, 32'd0);
        chk("rst/done", {31'd0, bus.done_o}, 32'd0);
        chk("rst/err", {31'd0, bus.err_o}, 32'd0);
        chk("rst/mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst/mem_wdata", bus.mem_wdata_o, 32'h0);
        rst_i = 1'b1;
        tick();

        // 1: byte store into lane 3
        mem[32'h100 >> 2] = 32'h1122_3344;
        run_store("sb_lane3", 32'h103, 32'hAABB_CC5A, 2'b00, 1'b0, 32'h5A22_3344);

        // 2: half store upper, byte store lane 1, half store lower
        mem[32'h100 >> 2] = 32'h1122_3344;
        run_store("sh_upper", 32'h102, 32'h0000_BEEF, 2'b01, 1'b0, 32'hBEEF_3344);
        mem[32'h100 >> 2] = 32'h1122_3344;
        run_store("sb_lane1", 32'h101, 32'h0000_0077, 2'b00, 1'b0, 32'h1122_7744);
        mem[32'h100 >> 2] = 32'h1122_3344;
        run_store("sh_lower", 32'h100, 32'h1234_ABCD, 2'b01, 1'b0, 32'h1122_ABCD);

        // 3: word store, no read phase
        run_store("sw", 32'h200, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // 4: misaligned / illegal, back to back
        run_store("sh_misal", 32'h101, 32'h0000_1234, 2'b01, 1'b1, 32'h0);
        run_store("sw_misal", 32'h202, 32'h1234_5678, 2'b10, 1'b1, 32'h0);
        run_store("size_11", 32'h100, 32'h1234_5678, 2'b11, 1'b1, 32'h0);

        // 5: wait states with stray responses
        mem[32'h300 >> 2] = 32'hA0B0_C0D0;
        rd_delay = 3;
        wr_delay = 2;
        stray_rv = 1'b1;
        stray_wk = 1'b1;
        run_store("sb_wait", 32'h302, 32'h1234_5681, 2'b00, 1'b0, 32'hA081_C0D0);
        rd_delay = 0;
        wr_delay = 0;
        stray_rv = 1'b0;
        stray_wk = 1'b0;

        // 6: reset while a half store waits for its write ack
        mem[32'h400 >> 2] = 32'h1122_3344;
        wr_delay = 10;
        bus.req_valid_i = 1'b1;
        bus.addr_i      = 32'h402;
        bus.wdata_i     = 32'h0000_CAFE;
        bus.size_i      = 2'b01;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        chk("rstmid/in_wr", {31'd0, bus.mem_wr_o}, 32'd1);
        tick();
        rst_i = 1'b0;
        #1;
        chk("rstmid/mem_wr", {31'd0, bus.mem_wr_o}, 32'd0);
        chk("rstmid/done", {31'd0, bus.done_o}, 32'd0);
        chk("rstmid/err", {31'd0, bus.err_o}, 32'd0);
        chk("rstmid/ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rstmid/mem_addr", bus.mem_addr_o, 32'h0);
        chk("rstmid/mem_wdata", bus.mem_wdata_o, 32'h0);
        tick();
        rst_i = 1'b1;
        wr_delay = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstmid/no_reissue", {31'd0, bus.mem_wr_o}, 32'd0);
            chk("rstmid/no_done", {31'd0, bus.done_o}, 32'd0);
        end
        chk("rstmid/no_write", wr_log.size(), 32'd0);
        chk("rstmid/mem_kept", mem[32'h400 >> 2], 32'h1122_3344);
        run_store("sb_after_rst", 32'h403, 32'h0000_0099, 2'b00, 1'b0, 32'h9922_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
